// File: rtl/ctrl_types.sv
`default_nettype none
// ============================================================================
// Package  : ctrl_types
// Brief    : RV32IM control word, RVFI record and decode-queue entry types.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_types;

  localparam int c_default_decode_width = 2;
  localparam int c_default_queue_depth  = 8;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  // ALU encodings line up with funct3 except the sra/sub alternates.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    br_beq  = 3'b000,
    br_bne  = 3'b001,
    br_blt  = 3'b100,
    br_bge  = 3'b101,
    br_bltu = 3'b110,
    br_bgeu = 3'b111
  } branch_funct3;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    alu_ops      aluop;
    logic [2:0]  cmpop;
    logic [2:0]  mulop;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_valid;
    logic        rs2_valid;
    logic        load_regfile;
    logic        alu_valid;
    logic        cmp_valid;
    logic        mul_valid;
    logic        load_valid;
    logic        store_valid;
  } rv32i_control_word;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_data;

  typedef struct packed {
    rv32i_control_word ctrl;
    rvfi_data          rvfi;
    logic              illegal;
  } decode_entry_t;

endpackage
`default_nettype wire

// File: rtl/decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : decode_unit
// Brief    : Single-lane combinational RV32IM decoder producing a queue entry.
// Revision : 1.0 - initial release
// ============================================================================
module decode_unit
  import ctrl_types::*;
(
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  input  rvfi_data      rvfi_in,
  output decode_entry_t entry
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_f7_mul;
  logic              w_f7_alt;
  logic [31:0]       w_imm_i;
  logic [31:0]       w_imm_s;
  logic [31:0]       w_imm_b;
  logic [31:0]       w_imm_u;
  logic [31:0]       w_imm_j;
  rv32i_control_word w_ctrl;
  logic              w_illegal;
  logic              w_writes_rd;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_f7_mul = instr[25];
  assign w_f7_alt = instr[30];
  assign w_imm_i  = {{21{instr[31]}}, instr[30:20]};
  assign w_imm_s  = {{21{instr[31]}}, instr[30:25], instr[11:7]};
  assign w_imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u  = {instr[31:12], 12'h000};
  assign w_imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.pc     = pc;
    w_ctrl.opcode = w_opcode;
    w_ctrl.funct3 = w_funct3;
    w_ctrl.rs1    = instr[19:15];
    w_ctrl.rs2    = instr[24:20];
    w_ctrl.rd     = instr[11:7];
    w_ctrl.aluop  = alu_ops'(w_funct3);
    w_ctrl.cmpop  = w_funct3;
    w_ctrl.mulop  = w_funct3;
    w_illegal     = 1'b0;
    w_writes_rd   = 1'b0;
    case (w_opcode)
      op_b_lui, op_b_auipc: begin
        w_ctrl.imm       = w_imm_u;
        w_ctrl.aluop     = alu_add;
        w_ctrl.alu_valid = 1'b1;
        w_writes_rd      = 1'b1;
      end
      op_b_jal: begin
        w_ctrl.imm       = w_imm_j;
        w_ctrl.cmp_valid = 1'b1;
        w_writes_rd      = 1'b1;
      end
      op_b_jalr: begin
        w_ctrl.imm       = w_imm_i;
        w_ctrl.rs1_valid = 1'b1;
        w_ctrl.cmp_valid = 1'b1;
        w_writes_rd      = 1'b1;
      end
      op_b_br: begin
        w_ctrl.imm       = w_imm_b;
        w_ctrl.rs1_valid = 1'b1;
        w_ctrl.rs2_valid = 1'b1;
        w_ctrl.cmp_valid = 1'b1;
      end
      op_b_load: begin
        w_ctrl.imm        = w_imm_i;
        w_ctrl.rs1_valid  = 1'b1;
        w_ctrl.load_valid = 1'b1;
        w_writes_rd       = 1'b1;
      end
      op_b_store: begin
        w_ctrl.imm         = w_imm_s;
        w_ctrl.rs1_valid   = 1'b1;
        w_ctrl.rs2_valid   = 1'b1;
        w_ctrl.store_valid = 1'b1;
      end
      op_b_imm: begin
        w_ctrl.imm       = w_imm_i;
        w_ctrl.rs1_valid = 1'b1;
        w_writes_rd      = 1'b1;
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
          w_ctrl.cmp_valid = 1'b1;
          w_ctrl.cmpop     = (w_funct3 == 3'b010) ? br_blt : br_bltu;
        end else begin
          w_ctrl.alu_valid = 1'b1;
          if (w_funct3 == 3'b101 && w_f7_alt) w_ctrl.aluop = alu_sra;
        end
      end
      op_b_reg: begin
        w_ctrl.rs1_valid = 1'b1;
        w_ctrl.rs2_valid = 1'b1;
        w_writes_rd      = 1'b1;
        if (w_f7_mul) begin
          w_ctrl.mul_valid = 1'b1;
        end else if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
          w_ctrl.cmp_valid = 1'b1;
          w_ctrl.cmpop     = (w_funct3 == 3'b010) ? br_blt : br_bltu;
        end else begin
          w_ctrl.alu_valid = 1'b1;
          if (w_funct3 == 3'b101 && w_f7_alt) w_ctrl.aluop = alu_sra;
          if (w_funct3 == 3'b000 && w_f7_alt) w_ctrl.aluop = alu_sub;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally dead, so never claim the regfile port.
    w_ctrl.load_regfile = w_writes_rd && (w_ctrl.rd != 5'd0);
  end

  always_comb begin
    entry               = '0;
    entry.ctrl          = w_ctrl;
    entry.illegal       = w_illegal;
    entry.rvfi          = rvfi_in;
    entry.rvfi.rs1_addr = w_ctrl.rs1_valid ? w_ctrl.rs1 : 5'd0;
    entry.rvfi.rs2_addr = w_ctrl.rs2_valid ? w_ctrl.rs2 : 5'd0;
  end

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Brief    : Multi-lane decode stage feeding a circular queue of decoded entries.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue
  import ctrl_types::*;
#(
  parameter int DECODE_WIDTH = c_default_decode_width,
  parameter int QUEUE_DEPTH  = c_default_queue_depth
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [DECODE_WIDTH-1:0]           fetch_valid,
  input  logic [31:0]                       fetch_pc    [DECODE_WIDTH],
  input  logic [31:0]                       fetch_instr [DECODE_WIDTH],
  input  rvfi_data                          fetch_rvfi  [DECODE_WIDTH],
  output logic                              fetch_ready,
  output logic [DECODE_WIDTH-1:0]           disp_valid,
  output rv32i_control_word                 disp_ctrl   [DECODE_WIDTH],
  output rvfi_data                          disp_rvfi   [DECODE_WIDTH],
  output logic [DECODE_WIDTH-1:0]           disp_illegal,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0] disp_take
);

  localparam int c_ptr_w  = $clog2(QUEUE_DEPTH);
  localparam int c_cnt_w  = $clog2(QUEUE_DEPTH + 1);
  localparam int c_take_w = $clog2(DECODE_WIDTH + 1);

  decode_entry_t      w_dec [DECODE_WIDTH];
  decode_entry_t      r_mem [QUEUE_DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_space;
  logic [c_cnt_w-1:0] w_enq_n;
  logic [c_cnt_w-1:0] w_deq_n;
  logic               w_enq;

  for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
    decode_unit u_decode (
      .pc      (fetch_pc[i]),
      .instr   (fetch_instr[i]),
      .rvfi_in (fetch_rvfi[i]),
      .entry   (w_dec[i])
    );
  end

  // Readiness depends only on registered occupancy so it never loops back through fetch.
  assign w_space     = c_cnt_w'(QUEUE_DEPTH) - r_count;
  assign fetch_ready = rst_n && !flush && (w_space >= c_cnt_w'(DECODE_WIDTH));
  assign w_enq       = fetch_ready && fetch_valid[0];
  assign w_deq_n     = flush ? '0 : c_cnt_w'(disp_take);

  always_comb begin
    w_enq_n = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      w_enq_n = w_enq_n + c_cnt_w'(fetch_valid[i]);
    end
    if (!w_enq) w_enq_n = '0;
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        if (fetch_valid[i]) r_mem[r_tail + c_ptr_w'(i)] <= w_dec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_ptr_w'(w_deq_n);
      r_tail  <= r_tail + c_ptr_w'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_disp
    decode_entry_t w_ent;
    assign w_ent           = r_mem[r_head + c_ptr_w'(i)];
    assign disp_valid[i]   = r_count > c_cnt_w'(i);
    assign disp_ctrl[i]    = w_ent.ctrl;
    assign disp_rvfi[i]    = w_ent.rvfi;
    assign disp_illegal[i] = w_ent.illegal;
  end

`ifndef SYNTHESIS
  logic [DECODE_WIDTH-1:0] w_fv_inc;
  assign w_fv_inc = fetch_valid + DECODE_WIDTH'(1);

  a_fetch_contiguous : assert property (@(posedge clk) disable iff (!rst_n)
    (fetch_valid & w_fv_inc) == '0)
    else $error("decode_queue: non-contiguous fetch_valid %b", fetch_valid);

  a_take_in_range : assert property (@(posedge clk) disable iff (!rst_n || flush)
    (c_cnt_w'(disp_take) <= r_count) && (disp_take <= c_take_w'(DECODE_WIDTH)))
    else $error("decode_queue: disp_take %0d exceeds valid lanes", disp_take);
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Brief    : Directed self-checking bench for decode_queue (2 lanes, depth 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;
  import ctrl_types::*;

  localparam int DW = 2;
  localparam int QD = 8;
  localparam logic [31:0] c_addi = 32'h00500093;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic [DW-1:0]     fetch_valid = '0;
  logic [31:0]       fetch_pc    [DW];
  logic [31:0]       fetch_instr [DW];
  rvfi_data          fetch_rvfi  [DW];
  logic              fetch_ready;
  logic [DW-1:0]     disp_valid;
  rv32i_control_word disp_ctrl   [DW];
  rvfi_data          disp_rvfi   [DW];
  logic [DW-1:0]     disp_illegal;
  logic [1:0]        disp_take = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc [$];
  logic [31:0] next_pc = 32'h0000_1000;

  decode_queue #(.DECODE_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_instr  (fetch_instr),
    .fetch_rvfi   (fetch_rvfi),
    .fetch_ready  (fetch_ready),
    .disp_valid   (disp_valid),
    .disp_ctrl    (disp_ctrl),
    .disp_rvfi    (disp_rvfi),
    .disp_illegal (disp_illegal),
    .disp_take    (disp_take)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_dv();
    if (exp_pc.size() >= 2) return 2'b11;
    if (exp_pc.size() == 1) return 2'b01;
    return 2'b00;
  endfunction

  // One clock: present a fetch group and a dispatch take, check, then update the model.
  task automatic cycle(input logic [1:0] fv, input int take, input logic [31:0] i0, input logic [31:0] i1);
    bit ready_exp;
    ready_exp = (QD - exp_pc.size()) >= DW;
    for (int i = 0; i < DW; i++) begin
      fetch_pc[i]             = next_pc + 32'(4 * i);
      fetch_instr[i]          = (i == 0) ? i0 : i1;
      fetch_rvfi[i]           = '0;
      fetch_rvfi[i].inst      = fetch_instr[i];
      fetch_rvfi[i].pc_rdata  = fetch_pc[i];
      fetch_rvfi[i].rs1_addr  = 5'h1f;
      fetch_rvfi[i].rs2_addr  = 5'h1f;
    end
    fetch_valid = fv;
    disp_take   = 2'(take);
    #1;
    check("fetch_ready", 64'(fetch_ready), 64'(ready_exp));
    check("disp_valid", 64'(disp_valid), 64'(exp_dv()));
    for (int i = 0; i < take; i++) check("disp_pc", 64'(disp_rvfi[i].pc_rdata), 64'(exp_pc[i]));
    tick();
    for (int i = 0; i < take; i++) void'(exp_pc.pop_front());
    if (ready_exp && fv[0]) begin
      for (int i = 0; i < DW; i++) begin
        if (fv[i]) begin
          exp_pc.push_back(next_pc);
          next_pc = next_pc + 32'd4;
        end
      end
    end
    fetch_valid = '0;
    disp_take   = '0;
  endtask

  initial begin
    for (int i = 0; i < DW; i++) begin
      fetch_pc[i] = '0;
      fetch_instr[i] = '0;
      fetch_rvfi[i] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_disp_valid", 64'(disp_valid), 64'h0);
    check("rst_fetch_ready", 64'(fetch_ready), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(fetch_ready), 64'h1);
    check("post_rst_valid", 64'(disp_valid), 64'h0);

    // addi x1,x0,5 in lane 0 only
    cycle(2'b01, 0, c_addi, 32'h0);
    check("addi_disp_valid", 64'(disp_valid), 64'h1);
    check("addi_aluop", 64'(disp_ctrl[0].aluop), 64'h0);
    check("addi_imm", 64'(disp_ctrl[0].imm), 64'h5);
    check("addi_load_regfile", 64'(disp_ctrl[0].load_regfile), 64'h1);
    check("addi_alu_valid", 64'(disp_ctrl[0].alu_valid), 64'h1);
    check("addi_rs2_valid", 64'(disp_ctrl[0].rs2_valid), 64'h0);
    check("addi_rvfi_rs2", 64'(disp_rvfi[0].rs2_addr), 64'h0);
    check("addi_illegal", 64'(disp_illegal[0]), 64'h0);
    cycle(2'b00, 1, 32'h0, 32'h0);

    // addi x0 and an illegal opcode
    cycle(2'b11, 0, 32'h00000013, 32'hFFFFFFFF);
    check("x0_load_regfile", 64'(disp_ctrl[0].load_regfile), 64'h0);
    check("x0_alu_valid", 64'(disp_ctrl[0].alu_valid), 64'h1);
    check("ill_flag", 64'(disp_illegal[1]), 64'h1);
    check("ill_valids", 64'({disp_ctrl[1].load_regfile, disp_ctrl[1].alu_valid,
                             disp_ctrl[1].cmp_valid, disp_ctrl[1].mul_valid,
                             disp_ctrl[1].load_valid, disp_ctrl[1].store_valid,
                             disp_ctrl[1].rs1_valid, disp_ctrl[1].rs2_valid}), 64'h0);
    cycle(2'b00, 2, 32'h0, 32'h0);

    // mul x3,x1,x2 and sub x5,x6,x7
    cycle(2'b11, 0, 32'h022081B3, 32'h407302B3);
    check("mul_mul_valid", 64'(disp_ctrl[0].mul_valid), 64'h1);
    check("mul_alu_valid", 64'(disp_ctrl[0].alu_valid), 64'h0);
    check("mul_mulop", 64'(disp_ctrl[0].mulop), 64'h0);
    check("mul_rvfi_rs2", 64'(disp_rvfi[0].rs2_addr), 64'h2);
    check("sub_aluop", 64'(disp_ctrl[1].aluop), 64'h3);
    check("sub_rd", 64'(disp_ctrl[1].rd), 64'h5);
    cycle(2'b00, 2, 32'h0, 32'h0);

    // lui x5,0x12345 and beq x1,x2,+8
    cycle(2'b11, 0, 32'h123452B7, 32'h00208463);
    check("lui_imm", 64'(disp_ctrl[0].imm), 64'h12345000);
    check("lui_rs1_valid", 64'(disp_ctrl[0].rs1_valid), 64'h0);
    check("lui_rvfi_rs1", 64'(disp_rvfi[0].rs1_addr), 64'h0);
    check("beq_cmp_valid", 64'(disp_ctrl[1].cmp_valid), 64'h1);
    check("beq_imm", 64'(disp_ctrl[1].imm), 64'h8);
    check("beq_load_regfile", 64'(disp_ctrl[1].load_regfile), 64'h0);
    cycle(2'b00, 2, 32'h0, 32'h0);

    // Fill to 8, drain 2 at full, refill to 7, then walk down to 3
    for (int g = 0; g < 4; g++) cycle(2'b11, 0, c_addi, c_addi);
    cycle(2'b00, 2, 32'h0, 32'h0);
    cycle(2'b00, 0, 32'h0, 32'h0);
    cycle(2'b01, 0, c_addi, c_addi);
    cycle(2'b11, 0, c_addi, c_addi);
    cycle(2'b00, 2, 32'h0, 32'h0);
    cycle(2'b00, 2, 32'h0, 32'h0);

    // Enqueue 2 while taking 1 at count 3, then stream 20 groups through
    cycle(2'b11, 1, c_addi, c_addi);
    for (int g = 0; g < 20; g++) cycle(2'b11, 2, c_addi, c_addi);

    // Flush at count 5 with a full group arriving
    cycle(2'b01, 0, c_addi, c_addi);
    flush       = 1'b1;
    fetch_valid = 2'b11;
    disp_take   = 2'd2;
    #1;
    check("flush_ready_low", 64'(fetch_ready), 64'h0);
    tick();
    flush       = 1'b0;
    fetch_valid = '0;
    disp_take   = '0;
    exp_pc.delete();
    #1;
    check("flush_disp_valid", 64'(disp_valid), 64'h0);
    check("flush_ready", 64'(fetch_ready), 64'h1);
    cycle(2'b11, 0, c_addi, c_addi);
    cycle(2'b11, 2, c_addi, c_addi);

    // Asynchronous reset mid-stream at count 2..4
    cycle(2'b11, 0, c_addi, c_addi);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(disp_valid), 64'h0);
    check("async_rst_ready", 64'(fetch_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    exp_pc.delete();
    #1;
    check("rel_ready", 64'(fetch_ready), 64'h1);
    check("rel_valid", 64'(disp_valid), 64'h0);
    cycle(2'b11, 0, c_addi, c_addi);
    cycle(2'b00, 2, 32'h0, 32'h0);
    cycle(2'b00, 0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DECODE_WIDTH, default 2, instructions decoded and dispatched per cycle (legal 1..4).
REQ-002 Parameter QUEUE_DEPTH, default 8, decoded-entry storage (power of 2, >= 2*DECODE_WIDTH).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 flush  in  1  mispredict/exception flush; discards all held and arriving entries.
REQ-006 fetch_valid  in  DECODE_WIDTH  per-lane instruction valid; lanes contiguous from lane 0.
REQ-007 fetch_pc  in  DECODE_WIDTH x 32  per-lane PC.
REQ-008 fetch_instr  in  DECODE_WIDTH x 32  per-lane raw instruction.
REQ-009 fetch_rvfi  in  DECODE_WIDTH x rvfi_data  per-lane RVFI record.
REQ-010 fetch_ready  out  1  queue accepts a full fetch group this cycle.
REQ-011 disp_valid  out  DECODE_WIDTH  lane i valid when occupancy > i.
REQ-012 disp_ctrl  out  DECODE_WIDTH x rv32i_control_word  decoded words, oldest in lane 0.
REQ-013 disp_rvfi  out  DECODE_WIDTH x rvfi_data  RVFI records, rs1/rs2 addr zeroed when the source is unused.
REQ-014 disp_illegal  out  DECODE_WIDTH  per-lane illegal-instruction flag.
REQ-015 disp_take  in  $clog2(DECODE_WIDTH+1)  number of oldest entries consumed by dispatch this cycle.

Function
REQ-016 Decode SHALL be combinational per lane at enqueue; decoded word, illegal flag and RVFI stored in the queue entry.
REQ-017 Decode rules SHALL match the existing RV32IM control word: LUI/AUIPC rs1_valid=0; JAL/JALR/BR/SLT/SLTU cmp unit; LOAD/STORE LSQ valids; OP funct7[0]=1 mul unit with mulop from funct3; SRA/SUB from funct7[5].
REQ-018 Opcode outside {lui,auipc,jal,jalr,br,load,store,imm,reg} SHALL set illegal=1 with load_regfile, alu/cmp/mul/load/store valids and rs1/rs2 valids all 0.
REQ-019 rd==x0 SHALL force load_regfile=0 (new vs. prior decode).
REQ-020 fetch_ready SHALL be 1 iff (QUEUE_DEPTH - count) >= DECODE_WIDTH and flush=0; computed from registered count only.
REQ-021 Enqueue SHALL occur when fetch_ready & fetch_valid[0]; popcount(fetch_valid) entries written in lane order at tail.
REQ-022 Dequeue SHALL remove disp_take entries from head; disp_take > number of valid disp lanes is illegal use (assertion).
REQ-023 Simultaneous enqueue and dequeue SHALL update count = count + enq - deq in one cycle.
REQ-024 Head/tail pointers SHALL wrap modulo QUEUE_DEPTH; count width $clog2(QUEUE_DEPTH+1).
REQ-025 Latency: an instruction enqueued at edge N SHALL appear on disp lanes in the cycle after edge N.
REQ-026 flush SHALL zero count and pointers at the next edge; enqueue and dequeue in the flush cycle ignored.
REQ-027 Non-contiguous fetch_valid (e.g. 2'b10) is illegal use (assertion); no enqueue required.

Reset
REQ-028 rst_n low SHALL immediately clear head, tail, count; disp_valid=0, fetch_ready=0 while low.
REQ-029 After rst_n deasserts, fetch_ready SHALL be 1 in the first cycle; entry storage need not be reset.
REQ-030 Reset mid-operation SHALL discard all entries; no partial group survives.

Structure
REQ-031 DECODE_WIDTH/QUEUE_DEPTH defaults and decode_entry_t (ctrl, rvfi, illegal) SHALL live in ctrl_types.
REQ-032 Per-lane decode SHALL be a sub-module decode_unit, instantiated DECODE_WIDTH times by generate.

Verification
REQ-033 Reset, then enqueue addi x1,x0,5 (0x00500093) lane 0 only -> next cycle disp_valid=01, aluop=add, imm=5, load_regfile=1.
REQ-034 Enqueue 0x00000013 (addi x0) -> load_regfile=0; enqueue 0xFFFFFFFF -> disp_illegal=1, all unit valids 0.
REQ-035 Fill to 8 with disp_take=0 -> fetch_ready=0 at count 7 and 8; disp_take=2 at count 8 -> count 6, fetch_ready=1.
REQ-036 Enqueue 2 while disp_take=1 at count 3 -> count 4; run 20 groups through -> pointer wrap, in-order PCs preserved.
REQ-037 flush with count 5 and fetch_valid=11 -> next cycle count 0, disp_valid=00.
REQ-038 rst_n low mid-stream (count 4) -> disp_valid=00 without a clock edge; after release fetch_ready=1.
